// File: rtl/alu_exec_unit.sv
// alu_exec_unit: register-file ALU that runs each command through IDLE/READ/EXEC/WRITE
module alu_exec_unit #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [AW-1:0]    i_cmd_rs1,
    input  logic [AW-1:0]    i_cmd_rs2,
    input  logic [AW-1:0]    i_cmd_rd,
    input  logic             i_ld_valid,
    input  logic [AW-1:0]    i_ld_addr,
    input  logic [WIDTH-1:0] i_ld_data,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_carry,
    output logic             o_rsp_overflow,
    output logic             o_rsp_zero,
    output logic             o_rsp_illegal
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_regs [DEPTH];
    logic [2:0]         r_op;
    logic [AW-1:0]      r_rs1;
    logic [AW-1:0]      r_rs2;
    logic [AW-1:0]      r_rd;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_illegal;
    logic               w_accept;
    logic               w_load;
    logic               w_wb;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;
    logic               w_ovf;
    logic               w_illegal;

    // A pending load has priority over a command, so a load blocks acceptance.
    assign o_cmd_ready = (r_state == IDLE) & ~i_ld_valid;
    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign w_load      = (r_state == IDLE) & i_ld_valid & (i_ld_addr != '0);
    assign w_wb        = (r_state == WRITE) & ~r_illegal & (r_rd != '0);

    assign o_rsp_valid    = (r_state == WRITE);
    assign o_rsp_result   = r_result;
    assign o_rsp_carry    = r_carry;
    assign o_rsp_overflow = r_ovf;
    assign o_rsp_zero     = r_zero;
    assign o_rsp_illegal  = r_illegal;

    // Overflow is the carry into the MSB xor the carry out; the carry-in is
    // recovered from the operand MSBs and the sum MSB.
    assign w_add     = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub     = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_ovf = (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_add[WIDTH-1]) ^ w_add[WIDTH];
    assign w_sub_ovf = (r_a[WIDTH-1] ^ ~r_b[WIDTH-1] ^ w_sub[WIDTH-1]) ^ w_sub[WIDTH];

    // State register; reset aborts any command in flight.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // Next-state logic: each command walks READ -> EXEC -> WRITE once.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? READ : IDLE;
            READ:    w_next = EXEC;
            EXEC:    w_next = WRITE;
            default: w_next = IDLE;
        endcase
    end

    // Register file; entry 0 is never written so it always reads as zero.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)  r_regs <= '{default: '0};
        else if (w_load) r_regs[i_ld_addr] <= i_ld_data;
        else if (w_wb)   r_regs[r_rd] <= r_result;
    end

    // Command fields captured on acceptance, operands captured in READ.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_op  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_rd  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= i_cmd_op;
                r_rs1 <= i_cmd_rs1;
                r_rs2 <= i_cmd_rs2;
                r_rd  <= i_cmd_rd;
            end
            if (r_state == READ) begin
                r_a <= r_regs[r_rs1];
                r_b <= r_regs[r_rs2];
            end
        end
    end

    // Operation decode; illegal opcodes leave result, carry and overflow at zero.
    always_comb begin
        w_result  = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (r_op)
            3'b000: w_result = r_a & r_b;
            3'b001: w_result = r_a | r_b;
            3'b010: begin
                w_result = w_add[WIDTH-1:0];
                w_carry  = w_add[WIDTH];
                w_ovf    = w_add_ovf;
            end
            3'b011: begin
                w_result = w_sub[WIDTH-1:0];
                w_carry  = w_sub[WIDTH];
                w_ovf    = w_sub_ovf;
            end
            3'b100:  w_result = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
            3'b101:  w_result = ~(r_a | r_b);
            default: w_illegal = 1'b1;
        endcase
    end

    // Response registers load in EXEC and then hold until the next command's EXEC.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == EXEC) begin
            r_result  <= w_result;
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
            r_zero    <= (w_result == '0);
            r_illegal <= w_illegal;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic model
module tb_alu_exec_unit;
    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_op = '0;
    logic [4:0]  i_cmd_rs1 = '0;
    logic [4:0]  i_cmd_rs2 = '0;
    logic [4:0]  i_cmd_rd = '0;
    logic        i_ld_valid = 1'b0;
    logic [4:0]  i_ld_addr = '0;
    logic [63:0] i_ld_data = '0;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_result;
    logic        o_rsp_carry;
    logic        o_rsp_overflow;
    logic        o_rsp_zero;
    logic        o_rsp_illegal;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] model [32];
    logic [63:0] last_res;
    logic [63:0] specials [6];

    alu_exec_unit dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_rs1(i_cmd_rs1), .i_cmd_rs2(i_cmd_rs2), .i_cmd_rd(i_cmd_rd),
        .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_result(o_rsp_result), .o_rsp_carry(o_rsp_carry),
        .o_rsp_overflow(o_rsp_overflow), .o_rsp_zero(o_rsp_zero), .o_rsp_illegal(o_rsp_illegal)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written as plain signed/unsigned arithmetic.
    task automatic ref_exec(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] r, output logic c, output logic v, output logic ill);
        logic [64:0] wide;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[63:0];
                c = wide[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'd3: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'd4: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd5: r = ~(a | b);
            default: ill = 1'b1;
        endcase
    endtask

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic do_load(input logic [4:0] addr, input logic [63:0] data);
        i_ld_valid = 1'b1;
        i_ld_addr = addr;
        i_ld_data = data;
        #1 chk("ready_during_load", o_cmd_ready, 0);
        @(posedge i_clock); #1;
        i_ld_valid = 1'b0;
        if (addr != 0) model[addr] = data;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        logic [63:0] er;
        logic ec, ev, ei;
        ref_exec(op, model[rs1], model[rs2], er, ec, ev, ei);
        i_cmd_op = op;
        i_cmd_rs1 = rs1;
        i_cmd_rs2 = rs2;
        i_cmd_rd = rd;
        i_cmd_valid = 1'b1;
        #1 chk("ready_idle", o_cmd_ready, 1);
        @(posedge i_clock); #1;
        i_cmd_valid = 1'b0;
        chk("busy_ready_t1", o_cmd_ready, 0);
        chk("rsp_valid_t1", o_rsp_valid, 0);
        @(posedge i_clock); #1;
        chk("busy_ready_t2", o_cmd_ready, 0);
        chk("rsp_valid_t2", o_rsp_valid, 0);
        @(posedge i_clock); #1;
        chk("rsp_valid_t3", o_rsp_valid, 1);
        chk("busy_ready_t3", o_cmd_ready, 0);
        chk("result", o_rsp_result, er);
        chk("carry", o_rsp_carry, ec);
        chk("overflow", o_rsp_overflow, ev);
        chk("zero", o_rsp_zero, er == 0);
        chk("illegal", o_rsp_illegal, ei);
        last_res = o_rsp_result;
        if (!ei && rd != 0) model[rd] = er;
        @(posedge i_clock); #1;
        chk("rsp_valid_t4", o_rsp_valid, 0);
        chk("ready_t4", o_cmd_ready, 1);
        chk("result_hold", o_rsp_result, er);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        specials = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0001};

        // Reset state
        #1;
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_result", o_rsp_result, 0);
        chk("rst_flags", {o_rsp_carry, o_rsp_overflow, o_rsp_zero, o_rsp_illegal}, 0);
        repeat (2) @(posedge i_clock);
        #1 i_reset_n = 1'b1;
        #1 chk("ready_after_release", o_cmd_ready, 1);
        @(posedge i_clock); #1;

        // Small add, then read back through r0
        do_load(5'd1, 64'd212);
        do_load(5'd2, 64'd32);
        run_cmd(3'd2, 5'd1, 5'd2, 5'd11);
        chk("add_244", last_res, 64'd244);
        run_cmd(3'd2, 5'd11, 5'd0, 5'd12);
        chk("readback_244", last_res, 64'd244);

        // Subtract with borrow and signed compares
        do_load(5'd7, 64'd632);
        do_load(5'd8, 64'd4321);
        run_cmd(3'd3, 5'd7, 5'd8, 5'd9);
        chk("sub_neg", last_res, 64'hFFFF_FFFF_FFFF_F197);
        run_cmd(3'd4, 5'd7, 5'd8, 5'd10);
        chk("slt_true", last_res, 64'd1);
        run_cmd(3'd4, 5'd8, 5'd7, 5'd10);
        chk("slt_false", last_res, 64'd0);

        // Signed overflow boundary
        do_load(5'd3, 64'h7FFF_FFFF_FFFF_FFFF);
        do_load(5'd4, 64'd1);
        run_cmd(3'd2, 5'd3, 5'd4, 5'd15);
        chk("add_ovf", last_res, 64'h8000_0000_0000_0000);
        run_cmd(3'd4, 5'd3, 5'd4, 5'd16);
        run_cmd(3'd4, 5'd15, 5'd3, 5'd16);
        run_cmd(3'd3, 5'd15, 5'd4, 5'd17);

        // Illegal opcodes never write; r0 ignores loads
        do_load(5'd5, 64'd99);
        run_cmd(3'd6, 5'd1, 5'd2, 5'd5);
        run_cmd(3'd7, 5'd1, 5'd2, 5'd5);
        run_cmd(3'd1, 5'd5, 5'd0, 5'd0);
        chk("r5_kept", last_res, 64'd99);
        do_load(5'd0, 64'd7);
        run_cmd(3'd1, 5'd0, 5'd0, 5'd18);
        chk("r0_zero", last_res, 64'd0);
        run_cmd(3'd5, 5'd0, 5'd0, 5'd19);
        run_cmd(3'd0, 5'd1, 5'd2, 5'd0);

        // Load held together with a command blocks acceptance
        i_ld_valid = 1'b1;
        i_ld_addr = 5'd20;
        i_ld_data = 64'd555;
        i_cmd_valid = 1'b1;
        i_cmd_op = 3'd2;
        i_cmd_rs1 = 5'd20;
        i_cmd_rs2 = 5'd0;
        i_cmd_rd = 5'd21;
        for (int k = 0; k < 3; k++) begin
            #1 chk("ready_while_load", o_cmd_ready, 0);
            @(posedge i_clock); #1;
        end
        i_ld_valid = 1'b0;
        model[20] = 64'd555;
        run_cmd(3'd2, 5'd20, 5'd0, 5'd21);
        chk("load_then_cmd", last_res, 64'd555);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_load(5'($urandom_range(0, 31)),
                        $urandom_range(0, 1) ? specials[$urandom_range(0, 5)] : {$urandom(), $urandom()});
            end else begin
                run_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
        end

        // Reset two cycles after acceptance aborts the command
        i_cmd_op = 3'd2;
        i_cmd_rs1 = 5'd1;
        i_cmd_rs2 = 5'd1;
        i_cmd_rd = 5'd22;
        i_cmd_valid = 1'b1;
        @(posedge i_clock); #1;
        i_cmd_valid = 1'b0;
        @(posedge i_clock); #1;
        i_reset_n = 1'b0;
        #1;
        chk("abort_rsp_valid", o_rsp_valid, 0);
        chk("abort_result", o_rsp_result, 0);
        chk("abort_ready", o_cmd_ready, 1);
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(posedge i_clock); #1;
        chk("abort_rsp_valid_2", o_rsp_valid, 0);
        i_reset_n = 1'b1;
        #1 chk("ready_after_abort", o_cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clock); #1;
            chk("no_late_rsp", o_rsp_valid, 0);
        end
        for (int r = 1; r < 32; r++) begin
            run_cmd(3'd1, 5'(r), 5'd0, 5'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 64, sets the operand, result and register width.
REQ-002 Parameter DEPTH, default 32, sets the register count; AW = clog2(DEPTH).
REQ-003 Port clock, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is an asynchronous active-low reset: assertion (0) immediately forces the reset state, and release is sampled on clock.
REQ-005 Port cmd_valid, input, 1, means a command is offered.
REQ-006 Port cmd_ready, output, 1, means a command can be accepted this cycle.
REQ-007 Port cmd_op, input, 3, selects the operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR; 110 and 111 are illegal.
REQ-008 Ports cmd_rs1, cmd_rs2 and cmd_rd are inputs of width AW: source 1, source 2 and destination register.
REQ-009 Port ld_valid, input, 1, requests a direct register load.
REQ-010 Ports ld_addr (input, AW) and ld_data (input, WIDTH) give the load address and data.
REQ-011 Port rsp_valid, output, 1, is a one-cycle pulse meaning the response fields are valid.
REQ-012 Port rsp_result, output, WIDTH, is the operation result.
REQ-013 Ports rsp_carry, rsp_overflow, rsp_zero and rsp_illegal are 1-bit outputs: carry out, signed overflow, result-is-zero and illegal opcode.

Function
REQ-014 The block shall hold a DEPTH x WIDTH register file in which register 0 reads as 0 and ignores writes.
REQ-015 The FSM shall have the states IDLE, READ, EXEC and WRITE; it shall be in IDLE after reset.
REQ-016 cmd_ready shall equal (state==IDLE) & ~ld_valid.
REQ-017 In IDLE with ld_valid=1, regs[ld_addr] <= ld_data; the state stays IDLE, and ld_addr=0 has no effect.
REQ-018 A command is accepted in IDLE when cmd_valid & cmd_ready; op, rs1, rs2 and rd are latched and the next state is READ.
REQ-019 ld_valid is ignored outside IDLE.
REQ-020 In READ, the operands A=regs[rs1] and B=regs[rs2] are latched; the next state is EXEC.
REQ-021 In EXEC, result and flags are computed and registered; the next state is WRITE.
REQ-022 In WRITE, if the op is legal and rd!=0, regs[rd] <= result.
REQ-023 In WRITE, rsp_valid=1 for exactly this one cycle; the next state is IDLE.
REQ-024 Latency: a command accepted at edge T gives rsp_valid high in cycle T+3, and cmd_ready is high again in cycle T+4.
REQ-025 Back-to-back commands have no hazard: the write completes before the next acceptance, so a following read of rd sees the new value.
REQ-026 ADD shall compute {carry, result} = A + B, using WIDTH+1-bit arithmetic.
REQ-027 SUB shall compute A + ~B + 1; rsp_carry=1 means no borrow.
REQ-028 For ADD and SUB, rsp_overflow shall be the carry into the MSB XOR the carry out of the MSB.
REQ-029 SLT shall give result = {WIDTH-1 zeros, sub_msb ^ sub_overflow}, a correct signed compare.
REQ-030 For SLT, rsp_carry and rsp_overflow shall be 0.
REQ-031 AND, OR and NOR are bitwise; for these, rsp_carry and rsp_overflow shall be 0.
REQ-032 rsp_zero shall be 1 exactly when rsp_result is 0.
REQ-033 An illegal op shall give result 0, rsp_illegal=1, rsp_zero=1 and carry/overflow 0, with no register write.
REQ-034 rsp_result and the flags shall hold their values until the next WRITE state.

Reset
REQ-035 Reset assertion shall clear all registers, outputs and flags to 0 and set the state to IDLE.
REQ-036 Reset asserted mid-command shall abort it: no write and no rsp_valid.
REQ-037 cmd_ready shall be 1 in the first cycle after reset release if ld_valid=0.

Verification
REQ-038 Load r1=212 and r2=32, then ADD rd=11 -> rsp_result=244, carry=0, ovf=0; a later ADD r11+r0 returns 244.
REQ-039 Load r7=632 and r8=4321, then SUB r7-r8 -> result=2^64-3689, carry=0, ovf=0; SLT r7,r8 -> 1; SLT r8,r7 -> 0.
REQ-040 Load r3=0x7FFF_FFFF_FFFF_FFFF and r4=1, then ADD -> 0x8000_0000_0000_0000, ovf=1, carry=0; SLT r3,r4 -> 0.
REQ-041 Issue op=110 with rd=5 holding 99 -> rsp_illegal=1, rsp_result=0, and r5 is still 99; a write of 7 to r0 followed by a read of r0 gives 0.
REQ-042 Assert reset two cycles after an accepted command -> no rsp_valid, all registers 0, cmd_ready=1 one cycle after release.
REQ-043 Hold cmd_valid and ld_valid together in IDLE -> the load takes effect and the command is accepted only after ld_valid drops; cmd_ready=0 throughout busy cycles.
